// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU result path.
package alu_pkg;

  localparam int ALU_WIDTH = 16;

  localparam int FLAG_C_IDX = 0;
  localparam int FLAG_V_IDX = 1;
  localparam int FLAG_Z_IDX = 2;
  localparam int FLAG_N_IDX = 3;

  // Field order matches the {N,Z,V,C} bit layout of the flags port.
  typedef struct packed {
    logic n;
    logic z;
    logic v;
    logic c;
  } alu_flags_t;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_FULL  = 2'd2
  } occ_e;

endpackage

// File: rtl/skid_buffer2.sv
// Two-entry valid/ready buffer: the head register drives the outputs and the skid register holds the
// overflow entry. in_ready is registered, so it never depends combinationally on out_ready.
module skid_buffer2
  import alu_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic [1:0]   occupancy
);

  occ_e         occ_q, occ_d;
  logic [W-1:0] head_q, head_d;
  logic [W-1:0] skid_q, skid_d;
  logic         in_ready_q, in_ready_d;
  logic         acc, pop;

  always_comb begin
    occ_d  = occ_q;
    head_d = head_q;
    skid_d = skid_q;
    acc    = in_valid & in_ready_q;
    pop    = (occ_q != OCC_EMPTY) & out_ready;
    unique case (occ_q)
      OCC_EMPTY: begin
        if (acc) begin
          head_d = in_data;
          occ_d  = OCC_ONE;
        end
      end
      OCC_ONE: begin
        if (acc && pop) begin
          head_d = in_data;
        end else if (acc) begin
          skid_d = in_data;
          occ_d  = OCC_FULL;
        end else if (pop) begin
          occ_d  = OCC_EMPTY;
        end
      end
      OCC_FULL: begin
        // in_ready_q is low here, so only a pop can happen.
        if (pop) begin
          head_d = skid_q;
          occ_d  = OCC_ONE;
        end
      end
      default: occ_d = OCC_EMPTY;
    endcase
    in_ready_d = (occ_d != OCC_FULL);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      occ_q      <= OCC_EMPTY;
      head_q     <= '0;
      skid_q     <= '0;
      in_ready_q <= 1'b1;
    end else begin
      occ_q      <= occ_d;
      head_q     <= head_d;
      skid_q     <= skid_d;
      in_ready_q <= in_ready_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = (occ_q != OCC_EMPTY);
  assign out_data  = head_q;
  assign occupancy = occ_q;

endmodule

// File: rtl/alu_result_stage.sv
// Registered stage after the ALU: buffers {dest, result} through a 2-entry skid buffer and
// keeps the architectural {N,Z,V,C} flags, updated in issue order at input acceptance.
module alu_result_stage
  import alu_pkg::*;
#(
  parameter int WIDTH  = ALU_WIDTH,
  parameter int DEST_W = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  alu_out,
  input  logic              alu_flag_carry,
  input  logic              alu_flag_overflow,
  input  logic [DEST_W-1:0] in_dest,
  input  logic              in_flag_we,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  out_data,
  output logic [DEST_W-1:0] out_dest,
  output logic [3:0]        flags,
  input  logic              flags_load_en,
  input  logic [3:0]        flags_load_val,
  output logic [1:0]        occupancy
);

  localparam int PW = WIDTH + DEST_W;

  logic [PW-1:0] out_payload;
  alu_flags_t    flags_q, flags_d;
  logic          accepted;

  skid_buffer2 #(.W(PW)) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   ({in_dest, alu_out}),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_payload),
    .occupancy (occupancy)
  );

  assign accepted = in_valid & in_ready;

  // A context restore wins over the flag update of a same-cycle accepted entry.
  always_comb begin
    flags_d = flags_q;
    if (flags_load_en) begin
      flags_d = alu_flags_t'(flags_load_val);
    end else if (accepted && in_flag_we) begin
      flags_d.c = alu_flag_carry;
      flags_d.v = alu_flag_overflow;
      flags_d.z = (alu_out == '0);
      flags_d.n = alu_out[WIDTH-1];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) flags_q <= '0;
    else        flags_q <= flags_d;
  end

  assign flags    = flags_q;
  assign out_data = out_payload[WIDTH-1:0];
  assign out_dest = out_payload[PW-1:WIDTH];

endmodule

// File: tb/tb_alu_result_stage.sv
// Scoreboard bench for alu_result_stage: accepted entries are queued, popped entries compared in order.
module tb_alu_result_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready;
  logic [15:0] alu_out;
  logic        alu_flag_carry, alu_flag_overflow;
  logic [2:0]  in_dest;
  logic        in_flag_we;
  logic        out_valid, out_ready;
  logic [15:0] out_data;
  logic [2:0]  out_dest;
  logic [3:0]  flags;
  logic        flags_load_en;
  logic [3:0]  flags_load_val;
  logic [1:0]  occupancy;

  always #5 clk = ~clk;

  alu_result_stage #(.WIDTH(16), .DEST_W(3)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .in_valid          (in_valid),
    .in_ready          (in_ready),
    .alu_out           (alu_out),
    .alu_flag_carry    (alu_flag_carry),
    .alu_flag_overflow (alu_flag_overflow),
    .in_dest           (in_dest),
    .in_flag_we        (in_flag_we),
    .out_valid         (out_valid),
    .out_ready         (out_ready),
    .out_data          (out_data),
    .out_dest          (out_dest),
    .flags             (flags),
    .flags_load_en     (flags_load_en),
    .flags_load_val    (flags_load_val),
    .occupancy         (occupancy)
  );

  int          n_checks = 0;
  int          n_errors = 0;
  int          n_pops   = 0;
  logic [18:0] sb[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock: account for this cycle's handshakes, then advance to #1 after the edge.
  task automatic cyc();
    logic [18:0] e;
    if (!rst_n) begin
      sb.delete();
    end else begin
      if (in_valid && in_ready) sb.push_back({in_dest, alu_out});
      if (out_valid && out_ready) begin
        n_pops++;
        if (sb.size() == 0) begin
          chk("unexpected_pop", {13'd0, out_dest, out_data}, 32'hFFFF_FFFF);
        end else begin
          e = sb.pop_front();
          chk("out_data", {16'd0, out_data}, {16'd0, e[15:0]});
          chk("out_dest", {29'd0, out_dest}, {29'd0, e[18:16]});
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  // Offer one entry and hold it until accepted (bounded).
  task automatic push_one(input logic [15:0] d, input logic [2:0] t, input logic we,
                          input logic c, input logic v);
    logic acc;
    logic done;
    done              = 1'b0;
    in_valid          = 1'b1;
    alu_out           = d;
    in_dest           = t;
    in_flag_we        = we;
    alu_flag_carry    = c;
    alu_flag_overflow = v;
    for (int i = 0; i < 20 && !done; i++) begin
      acc = in_ready;
      cyc();
      if (acc) done = 1'b1;
    end
    in_valid = 1'b0;
    if (!done) chk("push_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int pops0;
    rst_n = 1'b0; in_valid = 1'b0; alu_out = '0; alu_flag_carry = 1'b0;
    alu_flag_overflow = 1'b0; in_dest = '0; in_flag_we = 1'b0; out_ready = 1'b0;
    flags_load_en = 1'b0; flags_load_val = '0;
    cyc(); cyc();
    chk("rst_occ",       {30'd0, occupancy}, 32'd0);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_in_ready",  {31'd0, in_ready},  32'd1);
    chk("rst_flags",     {28'd0, flags},     32'd0);
    chk("rst_out_data",  {16'd0, out_data},  32'd0);
    chk("rst_out_dest",  {29'd0, out_dest},  32'd0);
    rst_n = 1'b1;
    cyc();

    // Single transfer with 1-cycle latency.
    out_ready = 1'b1;
    push_one(16'h1234, 3'd3, 1'b1, 1'b1, 1'b0);
    chk("t1_out_valid", {31'd0, out_valid}, 32'd1);
    chk("t1_out_data",  {16'd0, out_data},  32'h1234);
    chk("t1_out_dest",  {29'd0, out_dest},  32'd3);
    chk("t1_flags",     {28'd0, flags},     32'b0001);
    cyc();
    chk("t1_occ_after", {30'd0, occupancy}, 32'd0);

    // Back-pressure: third entry must wait for space.
    out_ready = 1'b0;
    pops0 = n_pops;
    push_one(16'h0001, 3'd1, 1'b0, 1'b0, 1'b0);
    push_one(16'h0002, 3'd2, 1'b0, 1'b0, 1'b0);
    chk("bp_occ_full",  {30'd0, occupancy}, 32'd2);
    chk("bp_in_ready",  {31'd0, in_ready},  32'd0);
    in_valid = 1'b1; alu_out = 16'h0003; in_dest = 3'd4;
    cyc(); cyc();
    chk("bp_held_occ", {30'd0, occupancy}, 32'd2);
    chk("bp_head",     {16'd0, out_data},  32'h0001);
    out_ready = 1'b1;
    for (int i = 0; i < 20 && (in_valid || sb.size() > 0); i++) begin
      logic acc;
      acc = in_valid & in_ready;
      cyc();
      if (acc) in_valid = 1'b0;
    end
    chk("bp_pops",    n_pops - pops0, 32'd3);
    chk("bp_drained", {30'd0, occupancy}, 32'd0);

    // Zero / negative flag derivation and write-enable gating.
    push_one(16'h0000, 3'd5, 1'b1, 1'b0, 1'b0);
    chk("flags_zero", {28'd0, flags}, 32'b0100);
    push_one(16'h8000, 3'd6, 1'b1, 1'b0, 1'b0);
    chk("flags_neg",  {28'd0, flags}, 32'b1000);
    push_one(16'h7FFF, 3'd7, 1'b0, 1'b1, 1'b1);
    chk("flags_hold", {28'd0, flags}, 32'b1000);
    cyc();

    // Flags load wins over a same-cycle update; the entry is still enqueued.
    flags_load_en = 1'b1; flags_load_val = 4'b1010;
    push_one(16'h00AA, 3'd2, 1'b1, 1'b1, 1'b0);
    flags_load_en = 1'b0;
    chk("load_flags", {28'd0, flags},     32'b1010);
    chk("load_valid", {31'd0, out_valid}, 32'd1);
    chk("load_data",  {16'd0, out_data},  32'h00AA);
    cyc();

    // Reset while full: held entries vanish.
    out_ready = 1'b0;
    push_one(16'hBEEF, 3'd1, 1'b1, 1'b1, 1'b1);
    push_one(16'hCAFE, 3'd2, 1'b1, 1'b1, 1'b1);
    chk("mr_occ_full", {30'd0, occupancy}, 32'd2);
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    chk("mr_out_valid", {31'd0, out_valid}, 32'd0);
    chk("mr_occ",       {30'd0, occupancy}, 32'd0);
    chk("mr_in_ready",  {31'd0, in_ready},  32'd1);
    chk("mr_flags",     {28'd0, flags},     32'd0);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("mr_no_emit", {31'd0, out_valid}, 32'd0);
    end

    // Streaming: one result per cycle at occupancy 1.
    pops0 = n_pops;
    in_valid = 1'b1; in_flag_we = 1'b0; in_dest = 3'd3;
    for (int i = 0; i < 32; i++) begin
      alu_out = 16'h0100 + 16'(i);
      cyc();
      chk("st_occ",  {30'd0, occupancy}, 32'd1);
      chk("st_data", {16'd0, out_data},  32'h0100 + 32'(i));
    end
    in_valid = 1'b0;
    cyc();
    chk("st_pops",  n_pops - pops0, 32'd32);
    chk("st_empty", {30'd0, occupancy}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/alu_result_stage.md
Name: alu_result_stage

Overview:
- Registered stage directly downstream of the combinational 16-bit ALU.
- Captures the ALU result word, carry/overflow flags and destination tag through a valid/ready handshake.
- Buffers up to two results in a skid buffer so that upstream ready never depends combinationally on downstream ready.
- Maintains the architectural flags register (C, V, Z, N) consumed by branch logic.

Parameters:
- WIDTH, 16, data width; must match the ALU data width.
- DEST_W, 3, width of the destination register tag.

Ports:
- clk  in  1  single system clock; all state changes on its rising edge.
- rst_n  in  1  synchronous, active-low reset.
- in_valid  in  1  ALU output and tag are valid this cycle.
- in_ready  out  1  stage can accept an entry; registered.
- alu_out  in  WIDTH  ALU result word.
- alu_flag_carry  in  1  ALU carry flag.
- alu_flag_overflow  in  1  ALU overflow flag.
- in_dest  in  DEST_W  destination register tag.
- in_flag_we  in  1  accepted entry updates the flags register.
- out_valid  out  1  out_data and out_dest are valid.
- out_ready  in  1  consumer accepts this cycle.
- out_data  out  WIDTH  head entry result.
- out_dest  out  DEST_W  head entry tag.
- flags  out  4  {N,Z,V,C} architectural flags.
- flags_load_en  in  1  overwrite the flags register (context restore).
- flags_load_val  in  4  {N,Z,V,C} value to load.
- occupancy  out  2  entries held (0..2).

Behaviour:
- Reset (rst_n low at a clk edge): occupancy=0, out_valid=0, in_ready=1, flags=4'b0000, out_data=0, out_dest=0. Reset mid-operation discards all held entries; no partial handshake survives.
- Accept on the input when in_valid & in_ready; pop on the output when out_valid & out_ready.
- Storage: head register (drives the outputs) and skid register. Both are FIFO ordered; the skid entry is never emitted before the head.
- States by occupancy:
  - EMPTY (0): accept -> ONE, data into head. The entry is visible on outputs the next cycle (1-cycle latency).
  - ONE (1):
    - accept and pop -> ONE; head <= new entry.
    - accept only -> FULL; new entry into skid.
    - pop only -> EMPTY.
  - FULL (2): in_ready=0.
    - pop -> ONE; head <= skid.
    - in_valid is ignored while full.
- in_ready is registered, equal to (next occupancy < 2). Consequence: the cycle after reaching FULL, in_ready=0 even if out_ready is high that cycle.
- out_valid = occupancy != 0. out_data/out_dest hold their value while out_valid & !out_ready.
- Simultaneous accept and pop in FULL cannot occur, because in_ready=0.
- Flags update at input acceptance (issue order), not at output pop:
  - C <= alu_flag_carry.
  - V <= alu_flag_overflow.
  - Z <= (alu_out == 0).
  - N <= alu_out[WIDTH-1].
  - Applies only when accepted & in_flag_we.
- flags_load_en has priority over a same-cycle flag update. The accepted entry is still enqueued.
- No arithmetic on data; widths pass through unchanged. occupancy never wraps: increment only from 0/1, decrement only from 1/2.

Decomposition:
- Shared package alu_pkg:
  - typedef alu_flags_t, packed struct {n,z,v,c}.
  - constants FLAG_C_IDX=0, FLAG_V_IDX=1, FLAG_Z_IDX=2, FLAG_N_IDX=3.
  - WIDTH default 16, matching the ALU.
- One natural sub-module: skid_buffer2, a generic 2-entry valid/ready buffer parameterised on payload width. alu_result_stage instantiates it with payload {in_dest, alu_out} and holds the flags register and its update/load logic itself.

Test Plan:
- Reset then single transfer: alu_out=16'h1234, dest=3, flag_we=1, C=1, V=0, out_ready=1.
  - One cycle later: out_valid=1, out_data=16'h1234, out_dest=3.
  - flags=4'b0001 after the accepting edge.
  - Next cycle: occupancy=0.
- Back-pressure: out_ready=0, push 16'h0001, 16'h0002, 16'h0003 on consecutive cycles.
  - First two accepted, then in_ready=0 and the third is held by the source.
  - Raise out_ready: outputs 0001, 0002, 0003 in order, no loss or duplication.
- Zero/negative flags: push 16'h0000 with flag_we=1 -> Z=1, N=0. Then push 16'h8000 -> Z=0, N=1. Then push 16'h7FFF with flag_we=0 -> flags unchanged (N=1).
- Load priority: same cycle as an accepted entry with C=1, flag_we=1, assert flags_load_en with 4'b1010.
  - flags=4'b1010 next cycle.
  - The entry still appears on out_data.
- Reset mid-operation: FULL with two entries, pulse rst_n=0 for one edge.
  - Next cycle: out_valid=0, occupancy=0, in_ready=1, flags=0.
  - The held entries are never emitted.
- Streaming throughput: in_valid=1 and out_ready=1 continuously for 32 cycles with an incrementing alu_out.
  - One result per cycle.
  - occupancy stays 1.
  - out_data sequence matches the input sequence delayed by one cycle.
